// File: rtl/fmul_norm_round.sv
// rtl/fmul_norm_round.sv - post-multiply normalise, RNE round and IEEE-754 pack, two-stage pipeline
//
// Purpose: takes the raw sign, biased exponent and full significand product from the
// multiplier datapath. Stage 1 normalises the product and extracts guard/sticky bits.
// Stage 2 rounds to nearest-even, handles specials, overflow and underflow, and packs the result.
// Both sides use valid/ready handshakes, so the consumer can stall the pipeline.
//
// Build option: FMUL_SUBNORMAL_EN. When defined, tiny results are denormalised and rounded.
// When undefined, tiny results flush to signed zero.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake
//   in_sign           result sign
//   in_exp            signed ea+eb-bias, EXP_W+2 bits
//   in_prod           significand product in [1,4) scaled by 2^(2*MAN_W)
//   in_cls            00 normal, 01 zero, 10 inf, 11 NaN
//   out_valid/out_ready output handshake
//   out               packed IEEE-754 result
//   out_ovf/unf/inx   overflow, underflow and inexact flags, qualified by out_valid
module fmul_norm_round #(
  parameter int N     = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W+1:0]     in_exp,
  input  logic [2*MAN_W+1:0]   in_prod,
  input  logic [1:0]           in_cls,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out,
  output logic                 out_ovf,
  output logic                 out_unf,
  output logic                 out_inx
);

  localparam int PW = 2*MAN_W+2;
  localparam int EW = EXP_W+2;
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  // Stage 1 state
  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [1:0]       s1_cls_q;
  logic [EW-1:0]    s1_exp_q,  s1_exp_d;
  logic [MAN_W:0]   s1_sig_q,  s1_sig_d;
  logic             s1_g_q,    s1_g_d;
  logic             s1_s_q,    s1_s_d;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q;
  logic [N-1:0]     res_q,     res_d;
  logic             ovf_q,     ovf_d;
  logic             unf_q,     unf_d;
  logic             inx_q,     inx_d;

  logic             s1_adv;
  logic             tiny;
  logic [MAN_W:0]   sig;
  logic             g, st, inc;
  logic [MAN_W+1:0] sum;
  logic [EW-1:0]    e_r;

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;

  assign out_valid = s2_valid_q;
  assign out       = res_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign out_inx   = inx_q;

  // Normalise: the product is in [1,4), so at most a one-bit right shift is needed.
  always_comb begin
    if (in_prod[PW-1]) begin
      s1_sig_d = in_prod[PW-1 -: MAN_W+1];
      s1_g_d   = in_prod[MAN_W];
      s1_s_d   = |in_prod[MAN_W-1:0];
      s1_exp_d = in_exp + EW'(1);
    end else begin
      s1_sig_d = in_prod[PW-2 -: MAN_W+1];
      s1_g_d   = in_prod[MAN_W-1];
      s1_s_d   = |in_prod[MAN_W-2:0];
      s1_exp_d = in_exp;
    end
  end

`ifdef FMUL_SUBNORMAL_EN
  localparam logic [EW-1:0] SH_MAX = EW'(MAN_W+2);
  logic [EW-1:0]      sh;
  logic [2*MAN_W+3:0] wide;
`endif

  always_comb begin
    sig   = s1_sig_q;
    g     = s1_g_q;
    st    = s1_s_q;
    tiny  = ($signed(s1_exp_q) <= 0);
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
`ifdef FMUL_SUBNORMAL_EN
    // Denormalise: shifting by more than MAN_W+2 pushes everything into sticky anyway.
    sh   = EW'(1) - s1_exp_q;
    if (sh > SH_MAX) sh = SH_MAX;
    wide = '0;
    if (tiny) begin
      wide = {s1_sig_q, s1_g_q, {(MAN_W+2){1'b0}}} >> sh;
      sig  = wide[2*MAN_W+3 -: MAN_W+1];
      g    = wide[MAN_W+2];
      st   = s1_s_q | (|wide[MAN_W+1:0]);
    end
`endif
    inc = g & (st | sig[0]);
    sum = {1'b0, sig} + (MAN_W+2)'(inc);
    e_r = s1_exp_q + EW'(sum[MAN_W+1]);

    case (s1_cls_q)
      2'b01:   res_d = {s1_sign_q, {(N-1){1'b0}}};
      2'b10:   res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      2'b11:   res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      default: begin
        if (tiny) begin
`ifdef FMUL_SUBNORMAL_EN
          // A rounding carry into the hidden bit promotes the result to the smallest normal.
          res_d = {s1_sign_q, {(EXP_W-1){1'b0}}, sum[MAN_W], sum[MAN_W-1:0]};
          inx_d = g | st;
          unf_d = g | st;
`else
          res_d = {s1_sign_q, {(N-1){1'b0}}};
          unf_d = 1'b1;
          inx_d = 1'b1;
`endif
        end else if ($signed(e_r) >= $signed(EMAX)) begin
          res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          res_d = {s1_sign_q, e_r[EXP_W-1:0],
                   sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0]};
          inx_d = g | st;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= '0;
      s1_exp_q   <= '0;
      s1_sig_q   <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_sign_q <= in_sign;
        s1_cls_q  <= in_cls;
        s1_exp_q  <= s1_exp_d;
        s1_sig_q  <= s1_sig_d;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
      end
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        res_q      <= res_d;
        ovf_q      <= ovf_d;
        unf_q      <= unf_d;
        inx_q      <= inx_d;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fmul_norm_round.sv
// tb/tb_fmul_norm_round.sv - directed self-checking bench for fmul_norm_round
module tb_fmul_norm_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [1:0]  in_cls;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inx;

  int n_cmp = 0;
  int n_bad = 0;

  fmul_norm_round #(.N(32), .EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_prod   (in_prod),
    .in_cls    (in_cls),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_inx   (out_inx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic sg, input logic [9:0] ex,
                       input logic [47:0] pr, input logic [1:0] cl);
    in_valid = v;
    in_sign  = sg;
    in_exp   = ex;
    in_prod  = pr;
    in_cls   = cl;
  endtask

  // One isolated transfer with out_ready high; checks latency and all result fields.
  task automatic run_vec(input string tag, input logic sg, input logic [9:0] ex,
                         input logic [47:0] pr, input logic [1:0] cl,
                         input logic [31:0] e_out, input logic e_ovf,
                         input logic e_unf, input logic e_inx);
    @(negedge clk);
    drive(1'b1, sg, ex, pr, cl);
    #1 chk($sformatf("%s_in_ready", tag), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("%s_lat1", tag), 64'(out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("%s_valid", tag), 64'(out_valid), 64'd1);
    chk($sformatf("%s_out", tag), 64'(out), 64'(e_out));
    chk($sformatf("%s_ovf", tag), 64'(out_ovf), 64'(e_ovf));
    chk($sformatf("%s_unf", tag), 64'(out_unf), 64'(e_unf));
    chk($sformatf("%s_inx", tag), 64'(out_inx), 64'(e_inx));
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 48'h0, 2'b00);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_flags", 64'({out_ovf, out_unf, out_inx}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;

    run_vec("mul_2p25", 1'b0, 10'd127, 48'h9000_0000_0000, 2'b00, 32'h4010_0000, 1'b0, 1'b0, 1'b0);
    run_vec("tie_even", 1'b0, 10'd127, 48'h4000_0040_0000, 2'b00, 32'h3F80_0000, 1'b0, 1'b0, 1'b1);
    run_vec("round_up", 1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, 32'h3F80_0002, 1'b0, 1'b0, 1'b1);
    run_vec("rnd_carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 2'b00, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    run_vec("overflow", 1'b1, 10'd254, 48'h8000_0000_0000, 2'b00, 32'hFF80_0000, 1'b1, 1'b0, 1'b1);
`ifdef FMUL_SUBNORMAL_EN
    run_vec("underflow", 1'b0, 10'd0, 48'h4000_0000_0000, 2'b00, 32'h0040_0000, 1'b0, 1'b0, 1'b0);
`else
    run_vec("underflow", 1'b0, 10'd0, 48'h4000_0000_0000, 2'b00, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
`endif
    run_vec("cls_zero", 1'b1, 10'd127, 48'h4000_0000_0000, 2'b01, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_vec("cls_inf", 1'b0, 10'd127, 48'h4000_0000_0000, 2'b10, 32'h7F80_0000, 1'b0, 1'b0, 1'b0);
    run_vec("cls_nan", 1'b1, 10'd127, 48'h4000_0000_0000, 2'b11, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0);

    // Back-pressure: A=2.25, B=-1.0, C=round-up; consumer stalled.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 10'd127, 48'h9000_0000_0000, 2'b00);
    #1 chk("bp_acc_a", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 10'd127, 48'h4000_0000_0000, 2'b00);
    #1 chk("bp_acc_b", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00);
    #1 chk("bp_hold_c", 64'(in_ready), 64'd0);
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_out", 64'(out), 64'h4010_0000);
    @(negedge clk);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_a_stable", 64'(out), 64'h4010_0000);
    out_ready = 1'b1;
    #1 chk("bp_release", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_out", 64'(out), 64'hBF80_0000);
    @(negedge clk);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    chk("bp_c_out", 64'(out), 64'h3F80_0002);
    chk("bp_c_inx", 64'(out_inx), 64'd1);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset with a result in flight: it must never appear.
    @(negedge clk);
    drive(1'b1, 1'b0, 10'd127, 48'h9000_0000_0000, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_out", 64'(out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
